// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and defaults for the two-port unified-memory arbiter.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package mem_arb_pkg;

  localparam int DEF_AW       = 32;
  localparam int DEF_DW       = 32;
  localparam int DEF_MAX_LOCK = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_t;

  // Width of a counter that must hold 0..max_lock inclusive.
  function automatic int lock_cnt_w(input int max_lock);
    return (max_lock < 1) ? 1 : $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose : bundle of both requester ports plus the memory-side bus.
// Latency : n/a (wires only); gnt is combinational, rvalid/rdata one cycle after a read gnt.
// Backpr. : a requester holds req/adr/we/wdata stable until it sees gnt.
// Ports   : m0_*/m1_* requester handshake and data, mem_* memory bus.
//           slave  = arbiter view, master = requesters + memory view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req,    m1_req;
  logic          m0_lock,   m1_lock;
  logic          m0_we,     m1_we;
  logic [AW-1:0] m0_adr,    m1_adr;
  logic [DW-1:0] m0_wdata,  m1_wdata;
  logic          m0_gnt,    m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata,  m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
    input  m0_adr, m1_adr, m0_wdata, m1_wdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output mem_we, mem_adr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
    output m0_adr, m1_adr, m0_wdata, m1_wdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  mem_we, mem_adr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arb_lockctr.sv
// Purpose : counts consecutive locked grants to the current owner; flags at_max.
// Latency : count updates at the clock edge; at_max is decoded from the register.
// Backpr. : none; saturates at MAX_LOCK instead of wrapping.
// Ports   : clk, reset (sync, active-high), inc, clr (clr wins), at_max.
module mem_arb_lockctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = lock_cnt_w(MAX_LOCK);

  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  assign at_max = (lock_cnt_q == CW'(MAX_LOCK));

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (clr) begin
      lock_cnt_d = '0;
    end else if (inc && !at_max) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates m0 (CPU) and m1 (host loader) onto one unified memory,
//           with optional lock and a bounded lock length to avoid starvation.
// Latency : gnt same cycle as req; read data + rvalid pulse one cycle after gnt.
// Backpr. : a losing requester simply keeps req high; no timeout.
// Ports   : clk, reset (sync, active-high), bus (mem_arbiter_if.slave).
// Config  : MEM_ARB_ROUND_ROBIN_EN defined -> round-robin on unlocked contention;
//           undefined -> fixed priority to m0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  owner_t        owner_q, owner_d;
  port_t         last_q,  last_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rv0_q,   rv0_d;
  logic          rv1_q,   rv1_d;

  logic          gnt0, gnt1, force_rel;
  logic          lock_inc, lock_clr, lock_at_max;
  logic [AW-1:0] adr_sel;
  logic [DW-1:0] wdata_sel;

  // Pick: an owner excludes the other port; the owner is cut off only when it
  // has used its full lock budget and the other port is waiting.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    force_rel = 1'b0;
    if (!reset) begin
      case (owner_q)
        OWN_M0: begin
          if (lock_at_max && bus.m1_req) force_rel = 1'b1;
          else                           gnt0      = bus.m0_req;
        end
        OWN_M1: begin
          if (lock_at_max && bus.m0_req) force_rel = 1'b1;
          else                           gnt1      = bus.m1_req;
        end
        default: begin
          if (bus.m0_req && bus.m1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_q == PORT_M1) gnt0 = 1'b1;
            else                   gnt1 = 1'b1;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
          end
        end
      endcase
    end
  end

  // Owner / last next state.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    if (gnt0) begin
      owner_d = bus.m0_lock ? OWN_M0 : OWN_NONE;
    end else if (gnt1) begin
      owner_d = bus.m1_lock ? OWN_M1 : OWN_NONE;
    end else if (force_rel) begin
      owner_d = OWN_NONE;
      // Marking the evicted owner as last hands the next contention to the other port.
      last_d  = (owner_q == OWN_M0) ? PORT_M0 : PORT_M1;
    end else if (owner_q == OWN_M0 && !bus.m0_lock) begin
      owner_d = OWN_NONE;
    end else if (owner_q == OWN_M1 && !bus.m1_lock) begin
      owner_d = OWN_NONE;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (gnt0)      last_d = PORT_M0;
    else if (gnt1) last_d = PORT_M1;
`endif
  end

  // Any transition to (or stay in) no-owner clears the lock run length.
  assign lock_inc = (gnt0 & bus.m0_lock) | (gnt1 & bus.m1_lock);
  assign lock_clr = (owner_d == OWN_NONE);

  mem_arb_lockctr #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lockctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (lock_inc),
    .clr    (lock_clr),
    .at_max (lock_at_max)
  );

  // Memory-side mux; zero address/data when idle.
  always_comb begin
    adr_sel   = '0;
    wdata_sel = '0;
    if (gnt0) begin
      adr_sel   = bus.m0_adr;
      wdata_sel = bus.m0_wdata;
    end else if (gnt1) begin
      adr_sel   = bus.m1_adr;
      wdata_sel = bus.m1_wdata;
    end
  end

  assign bus.mem_adr   = adr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_we    = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;

  // Read-data pipeline: capture on a granted read, hold otherwise.
  always_comb begin
    rv0_d   = gnt0 & ~bus.m0_we;
    rv1_d   = gnt1 & ~bus.m1_we;
    rdata_d = rdata_q;
    if (rv0_d || rv1_d) rdata_d = bus.mem_rdata;
  end

  // Outputs are masked during reset so a pulse registered just before reset
  // assertion never reaches the requester.
  assign bus.m0_rvalid = rv0_q & ~reset;
  assign bus.m1_rvalid = rv1_q & ~reset;
  assign bus.m0_rdata  = reset ? '0 : rdata_q;
  assign bus.m1_rdata  = reset ? '0 : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      last_q  <= PORT_M1;
      rdata_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter with a small memory model.
// Latency : inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpr. : requesters hold req until the expected grant cycle.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] mem [0:255];

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Combinational-read, synchronous-write memory; word index from byte address.
  assign bus.mem_rdata = mem[bus.mem_adr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_adr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic idle();
    bus.m0_req = 1'b0; bus.m0_lock = 1'b0; bus.m0_we = 1'b0;
    bus.m0_adr = '0;   bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_we = 1'b0;
    bus.m1_adr = '0;   bus.m1_wdata = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next_cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_adr = 32'h40; bus.m0_wdata = 32'hCAFE_0001;
    bus.m1_req = 1'b1; bus.m1_adr = 32'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00) $display("FAIL reset_gnt cyc%0d got %b want 00", i, {bus.m1_gnt, bus.m0_gnt});
      else n_pass++;
      n_chk++;
      if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we cyc%0d got %b want 0", i, bus.mem_we);
      else n_pass++;
      n_chk++;
      if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) $display("FAIL reset_rvalid cyc%0d got %b want 00", i, {bus.m1_rvalid, bus.m0_rvalid});
      else n_pass++;
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) $display("FAIL release_gnt got %b want 01", {bus.m1_gnt, bus.m0_gnt});
    else n_pass++;
    n_chk++;
    if (bus.mem_we !== 1'b1 || bus.mem_adr !== 32'h40) $display("FAIL release_write got we=%b adr=%h want we=1 adr=00000040", bus.mem_we, bus.mem_adr);
    else n_pass++;
    next_cyc();
    idle();
  endtask

  task automatic test_write_read();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_adr = 32'h10; bus.m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++;
    if (bus.m0_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_adr !== 32'h10 || bus.mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_issue got gnt=%b we=%b adr=%h wd=%h want 1 1 00000010 deadbeef", bus.m0_gnt, bus.mem_we, bus.mem_adr, bus.mem_wdata);
    else n_pass++;
    n_chk++;
    if (bus.m0_rvalid !== 1'b0) $display("FAIL wr_no_rvalid got %b want 0", bus.m0_rvalid);
    else n_pass++;
    next_cyc();
    bus.m0_we = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.m0_gnt !== 1'b1 || bus.mem_we !== 1'b0) $display("FAIL rd_issue got gnt=%b we=%b want gnt=1 we=0", bus.m0_gnt, bus.mem_we);
    else n_pass++;
    next_cyc();
    idle();
    @(negedge clk);
    n_chk++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'hDEAD_BEEF || bus.m1_rvalid !== 1'b0)
      $display("FAIL rd_data got rv0=%b rd=%h rv1=%b want 1 deadbeef 0", bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid);
    else n_pass++;
    n_chk++;
    if (bus.m1_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_shared got %h want deadbeef", bus.m1_rdata);
    else n_pass++;
    n_chk++;
    if (bus.mem_adr !== 32'h0 || bus.mem_we !== 1'b0) $display("FAIL idle_bus got adr=%h we=%b want 0 0", bus.mem_adr, bus.mem_we);
    else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if (bus.m0_rvalid !== 1'b0) $display("FAIL rvalid_pulse got %b want 0", bus.m0_rvalid);
    else n_pass++;
    next_cyc();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    do_reset();
    bus.m0_req = 1'b1; bus.m0_adr = 32'h20;
    bus.m1_req = 1'b1; bus.m1_adr = 32'h24;
    prev_g = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      n_chk++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_g) $display("FAIL contend_gnt cyc%0d got %b want %b", i, {bus.m1_gnt, bus.m0_gnt}, exp_g);
      else n_pass++;
      n_chk++;
      if ({bus.m1_rvalid, bus.m0_rvalid} !== prev_g) $display("FAIL contend_rv cyc%0d got %b want %b", i, {bus.m1_rvalid, bus.m0_rvalid}, prev_g);
      else n_pass++;
      if (prev_g != 2'b00) begin
        n_chk++;
        if (bus.m0_rdata !== ((prev_g == 2'b01) ? 32'h1000_0008 : 32'h1000_0009))
          $display("FAIL contend_rdata cyc%0d got %h want %h", i, bus.m0_rdata, (prev_g == 2'b01) ? 32'h1000_0008 : 32'h1000_0009);
        else n_pass++;
      end
      prev_g = exp_g;
      next_cyc();
    end
    idle();
    @(negedge clk);
    n_chk++;
    if ({bus.m1_rvalid, bus.m0_rvalid} !== prev_g) $display("FAIL contend_rv_last got %b want %b", {bus.m1_rvalid, bus.m0_rvalid}, prev_g);
    else n_pass++;
    next_cyc();
  endtask

  task automatic test_lock();
    logic [1:0] exp_t [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    do_reset();
    bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_adr = 32'h30;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin bus.m0_req = 1'b1; bus.m0_adr = 32'h20; end
      if (i == 3) begin bus.m1_req = 1'b0; bus.m1_lock = 1'b0; end
      @(negedge clk);
      n_chk++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_t[i]) $display("FAIL lock_gnt cyc%0d got %b want %b", i, {bus.m1_gnt, bus.m0_gnt}, exp_t[i]);
      else n_pass++;
      next_cyc();
    end
    idle();
    next_cyc();
  endtask

  task automatic test_forced_release();
    logic [1:0] exp_g;
    do_reset();
    bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_adr = 32'h34;
    for (int i = 0; i < 11; i++) begin
      if (i == 1) begin bus.m0_req = 1'b1; bus.m0_adr = 32'h20; end
      if (i < 8)       exp_g = 2'b10;
      else if (i == 8) exp_g = 2'b00;
      else if (i == 9) exp_g = 2'b01;
      else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = 2'b10;
`else
        exp_g = 2'b01;
`endif
      end
      @(negedge clk);
      n_chk++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_g) $display("FAIL force_gnt cyc%0d got %b want %b", i, {bus.m1_gnt, bus.m0_gnt}, exp_g);
      else n_pass++;
      next_cyc();
    end
    idle();
    next_cyc();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_g;
    do_reset();
    bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_adr = 32'h20;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) begin bus.m1_req = 1'b1; bus.m1_adr = 32'h24; end
      if (i < 10)       exp_g = 2'b01;
      else if (i == 10) exp_g = 2'b00;
      else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = 2'b10;
`else
        exp_g = 2'b01;
`endif
      end
      @(negedge clk);
      n_chk++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_g) $display("FAIL sat_gnt cyc%0d got %b want %b", i, {bus.m1_gnt, bus.m0_gnt}, exp_g);
      else n_pass++;
      next_cyc();
    end
    idle();
    next_cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_adr = 32'h50; bus.m0_wdata = 32'h1111_1111;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_adr = 32'h50; bus.m1_wdata = 32'h2222_2222;
    @(negedge clk);
    n_chk++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01 || bus.mem_wdata !== 32'h1111_1111)
      $display("FAIL b2b_w0 got gnt=%b wd=%h want 01 11111111", {bus.m1_gnt, bus.m0_gnt}, bus.mem_wdata);
    else n_pass++;
    next_cyc();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h2222_2222)
      $display("FAIL b2b_w1 got gnt=%b we=%b wd=%h want 10 1 22222222", {bus.m1_gnt, bus.m0_gnt}, bus.mem_we, bus.mem_wdata);
    else n_pass++;
    next_cyc();
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    bus.m0_req = 1'b1; bus.m0_adr = 32'h50;
    @(negedge clk);
    n_chk++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) $display("FAIL b2b_rd_gnt got %b want 01", {bus.m1_gnt, bus.m0_gnt});
    else n_pass++;
    next_cyc();
    idle();
    @(negedge clk);
    n_chk++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h2222_2222)
      $display("FAIL b2b_order got rv=%b rd=%h want 1 22222222", bus.m0_rvalid, bus.m0_rdata);
    else n_pass++;
    next_cyc();
  endtask

  task automatic test_reset_rvalid();
    bus.m0_req = 1'b1; bus.m0_adr = 32'h10;
    @(negedge clk);
    n_chk++;
    if (bus.m0_gnt !== 1'b1) $display("FAIL rst_rd_gnt got %b want 1", bus.m0_gnt);
    else n_pass++;
    next_cyc();
    reset = 1'b1;
    idle();
    @(negedge clk);
    n_chk++;
    if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 32'h0) $display("FAIL rst_drop got rv=%b rd=%h want 0 00000000", bus.m0_rvalid, bus.m0_rdata);
    else n_pass++;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 32'h0) $display("FAIL rst_after got rv=%b rd=%h want 0 00000000", bus.m0_rvalid, bus.m0_rdata);
    else n_pass++;
    next_cyc();
  endtask

  initial begin
    reset    = 1'b1;
    mem_init = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_contention();
    test_lock();
    test_forced_release();
    test_saturate();
    test_back_to_back();
    test_reset_rvalid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
